// File: rtl/lcd_spi_stream.sv
// rtl/lcd_spi_stream.sv - SPI LCD power-up sequencer, window setup and RGB565 pixel streamer
// Build macro LCD_SPI_TESTPATTERN_EN swaps the pix_* handshake for an internal three-band pattern.
module lcd_spi_stream #(
   parameter int unsigned CLK_DIV   = 1,
   parameter logic [15:0] COL_START = 16'd40,
   parameter logic [15:0] COL_END   = 16'd279,
   parameter logic [15:0] ROW_START = 16'd53,
   parameter logic [15:0] ROW_END   = 16'd187,
   parameter logic [7:0]  MADCTL    = 8'h70,
   parameter int unsigned T_RESET   = 2700000,
   parameter int unsigned T_PREPARE = 5400000,
   parameter int unsigned T_WAKE    = 3240000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        frame_start,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        lcd_resetn,
   output logic        lcd_clk,
   output logic        lcd_cs,
   output logic        lcd_rs,
   output logic        lcd_data,
   output logic        init_done,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [31:0] NPIX = (32'(COL_END) - 32'(COL_START) + 32'd1) *
                                  (32'(ROW_END) - 32'(ROW_START) + 32'd1);
   localparam logic [31:0] THIRD      = NPIX / 32'd3;
   localparam logic [31:0] TWO_THIRD  = THIRD * 32'd2;
   localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [31:0] RESET_LAST = 32'(T_RESET - 1);
   localparam logic [31:0] PREP_LAST  = 32'(T_PREPARE - 1);
   localparam logic [31:0] WAKE_LAST  = 32'(T_WAKE - 1);
   localparam logic [3:0]  N_INIT     = 4'd6;
   localparam logic [3:0]  N_WIN      = 4'd11;

   typedef enum logic [2:0] {
      ST_RESET, ST_PREPARE, ST_WAKEUP, ST_SNOOZE,
      ST_INIT, ST_IDLE, ST_WINDOW, ST_PIXEL
   } state_t;

   state_t      state, next_state;
   logic [31:0] cnt;
   logic [31:0] pix_cnt;
   logic [3:0]  idx;

   logic        sh_act;
   logic        sh_phase;
   logic [7:0]  sh_div;
   logic [4:0]  sh_bits;
   logic [15:0] sh_data;
   logic        sh_rs;

   logic        sh_start;
   logic [15:0] ld_data;
   logic [4:0]  ld_bits;
   logic        ld_rs;
   logic        cnt_clr;
   logic        idx_inc;
   logic        idx_clr;
   logic        pix_inc;
   logic [8:0]  rom_word;

   // {rs, byte} for the command/data byte at position idx of INIT or WINDOW
   always_comb begin
      rom_word = 9'h000;
      if (state == ST_WINDOW) begin
         case (idx)
            4'd0:    rom_word = {1'b0, 8'h2A};
            4'd1:    rom_word = {1'b1, COL_START[15:8]};
            4'd2:    rom_word = {1'b1, COL_START[7:0]};
            4'd3:    rom_word = {1'b1, COL_END[15:8]};
            4'd4:    rom_word = {1'b1, COL_END[7:0]};
            4'd5:    rom_word = {1'b0, 8'h2B};
            4'd6:    rom_word = {1'b1, ROW_START[15:8]};
            4'd7:    rom_word = {1'b1, ROW_START[7:0]};
            4'd8:    rom_word = {1'b1, ROW_END[15:8]};
            4'd9:    rom_word = {1'b1, ROW_END[7:0]};
            default: rom_word = {1'b0, 8'h2C};
         endcase
      end else begin
         case (idx)
            4'd0:    rom_word = {1'b0, 8'h36};
            4'd1:    rom_word = {1'b1, MADCTL};
            4'd2:    rom_word = {1'b0, 8'h3A};
            4'd3:    rom_word = {1'b1, 8'h05};
            4'd4:    rom_word = {1'b0, 8'h21};
            default: rom_word = {1'b0, 8'h29};
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_RESET;
      else         state <= next_state;
   end

   // The shifter counts as free during its trailing cs-high cycle, so back-to-back bytes
   // see exactly one idle cycle between them.
   always_comb begin
      next_state = state;
      sh_start   = 1'b0;
      ld_data    = {rom_word[7:0], 8'hFF};
      ld_bits    = 5'd8;
      ld_rs      = rom_word[8];
      cnt_clr    = 1'b0;
      idx_inc    = 1'b0;
      idx_clr    = 1'b0;
      pix_inc    = 1'b0;
      pix_ready  = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_RESET: begin
            if (cnt == RESET_LAST) begin
               next_state = ST_PREPARE;
               cnt_clr    = 1'b1;
            end
         end
         ST_PREPARE: begin
            if (cnt == PREP_LAST) next_state = ST_WAKEUP;
         end
         ST_WAKEUP: begin
            if (!sh_act) begin
               if (idx == 4'd0) begin
                  sh_start = 1'b1;
                  ld_data  = {8'h11, 8'hFF};
                  ld_rs    = 1'b0;
                  idx_inc  = 1'b1;
               end else begin
                  next_state = ST_SNOOZE;
                  idx_clr    = 1'b1;
                  cnt_clr    = 1'b1;
               end
            end
         end
         ST_SNOOZE: begin
            if (cnt == WAKE_LAST) next_state = ST_INIT;
         end
         ST_INIT: begin
            if (!sh_act) begin
               if (idx < N_INIT) begin
                  sh_start = 1'b1;
                  idx_inc  = 1'b1;
               end else begin
                  next_state = ST_IDLE;
                  idx_clr    = 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (frame_start) next_state = ST_WINDOW;
         end
         ST_WINDOW: begin
            if (!sh_act) begin
               if (idx < N_WIN) begin
                  sh_start = 1'b1;
                  idx_inc  = 1'b1;
               end else begin
                  next_state = ST_PIXEL;
                  idx_clr    = 1'b1;
               end
            end
         end
         ST_PIXEL: begin
            if (!sh_act) begin
               if (pix_cnt == NPIX) begin
                  frame_done = 1'b1;
                  next_state = ST_IDLE;
               end else begin
`ifdef LCD_SPI_TESTPATTERN_EN
                  sh_start = 1'b1;
                  pix_inc  = 1'b1;
                  ld_bits  = 5'd16;
                  ld_rs    = 1'b1;
                  ld_data  = (pix_cnt < THIRD) ? 16'h001F :
                             (pix_cnt < TWO_THIRD) ? 16'h07E0 : 16'hF800;
`else
                  if (pix_valid) begin
                     pix_ready = 1'b1;
                     sh_start  = 1'b1;
                     pix_inc   = 1'b1;
                     ld_bits   = 5'd16;
                     ld_rs     = 1'b1;
                     ld_data   = pix_data;
                  end
`endif
               end
            end
         end
         default: next_state = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         idx     <= '0;
         pix_cnt <= '0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + 32'd1;
         if (idx_clr)      idx <= '0;
         else if (idx_inc) idx <= idx + 4'd1;
         if (state == ST_IDLE) pix_cnt <= '0;
         else if (pix_inc)     pix_cnt <= pix_cnt + 32'd1;
      end
   end

   // Each bit: CLK_DIV cycles with lcd_clk low, then CLK_DIV high; shift on the high->low turn.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh_act   <= 1'b0;
         sh_phase <= 1'b0;
         sh_div   <= '0;
         sh_bits  <= '0;
         sh_data  <= '1;
         sh_rs    <= 1'b1;
      end else if (sh_start) begin
         sh_act   <= 1'b1;
         sh_phase <= 1'b0;
         sh_div   <= '0;
         sh_bits  <= ld_bits;
         sh_data  <= ld_data;
         sh_rs    <= ld_rs;
      end else if (sh_act) begin
         if (sh_div == DIV_LAST) begin
            sh_div <= '0;
            if (!sh_phase) begin
               sh_phase <= 1'b1;
            end else begin
               sh_phase <= 1'b0;
               sh_data  <= {sh_data[14:0], 1'b1};
               sh_bits  <= sh_bits - 5'd1;
               if (sh_bits == 5'd1) sh_act <= 1'b0;
            end
         end else begin
            sh_div <= sh_div + 8'd1;
         end
      end
   end

   assign lcd_resetn = (state != ST_RESET);
   assign busy       = (state != ST_IDLE);
   assign init_done  = (state == ST_IDLE) || (state == ST_WINDOW) || (state == ST_PIXEL);
   assign lcd_cs     = !sh_act;
   assign lcd_clk    = !sh_act || sh_phase;
   assign lcd_data   = !sh_act || sh_data[15];
   assign lcd_rs     = sh_rs;

endmodule

// File: tb/tb_lcd_spi_stream.sv
// tb/tb_lcd_spi_stream.sv - scoreboard bench for lcd_spi_stream (handles LCD_SPI_TESTPATTERN_EN builds too)
`timescale 1ns/1ps
module tb_lcd_spi_stream;

   localparam int unsigned CLK_DIV   = 2;
   localparam logic [15:0] COL_START = 16'h0135;
   localparam logic [15:0] COL_END   = 16'h0136;
   localparam logic [15:0] ROW_START = 16'h0000;
   localparam logic [15:0] ROW_END   = 16'h0001;
   localparam logic [7:0]  MADCTL    = 8'h70;
   localparam int unsigned T_RESET   = 4;
   localparam int unsigned T_PREPARE = 4;
   localparam int unsigned T_WAKE    = 4;
   localparam int NPIX = (int'(COL_END) - int'(COL_START) + 1) * (int'(ROW_END) - int'(ROW_START) + 1);

   logic        clk = 1'b0;
   logic        resetn;
   logic        frame_start;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready, lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data;
   logic        init_done, busy, frame_done;

   lcd_spi_stream #(
      .CLK_DIV(CLK_DIV), .COL_START(COL_START), .COL_END(COL_END),
      .ROW_START(ROW_START), .ROW_END(ROW_END), .MADCTL(MADCTL),
      .T_RESET(T_RESET), .T_PREPARE(T_PREPARE), .T_WAKE(T_WAKE)
   ) dut (
      .clk(clk), .resetn(resetn), .frame_start(frame_start),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .lcd_resetn(lcd_resetn), .lcd_clk(lcd_clk), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs),
      .lcd_data(lcd_data), .init_done(init_done), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pix;
      logic        rs;
      logic [15:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   pr_cnt   = 0;
   int   fd_cnt   = 0;
   int   pix_seen = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic push_byte(input logic rs, input logic [7:0] b);
      exp_t e;
      e.pix = 1'b0; e.rs = rs; e.val = {8'h00, b};
      exp_q.push_back(e);
   endtask

   task automatic push_pix(input logic [15:0] v);
      exp_t e;
      e.pix = 1'b1; e.rs = 1'b1; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic push_power();
      push_byte(1'b0, 8'h11);
      push_byte(1'b0, 8'h36); push_byte(1'b1, MADCTL);
      push_byte(1'b0, 8'h3A); push_byte(1'b1, 8'h05);
      push_byte(1'b0, 8'h21); push_byte(1'b0, 8'h29);
   endtask

   task automatic push_window();
      push_byte(1'b0, 8'h2A);
      push_byte(1'b1, COL_START[15:8]); push_byte(1'b1, COL_START[7:0]);
      push_byte(1'b1, COL_END[15:8]);   push_byte(1'b1, COL_END[7:0]);
      push_byte(1'b0, 8'h2B);
      push_byte(1'b1, ROW_START[15:8]); push_byte(1'b1, ROW_START[7:0]);
      push_byte(1'b1, ROW_END[15:8]);   push_byte(1'b1, ROW_END[7:0]);
      push_byte(1'b0, 8'h2C);
   endtask

   function automatic logic [15:0] pat(input int p);
      int third = NPIX / 3;
      if (p < third)          return 16'h001F;
      else if (p < 2 * third) return 16'h07E0;
      else                    return 16'hF800;
   endfunction

   // Bus monitor: decodes every cs-low frame, checks bit timing and pops the scoreboard.
   logic        prev_cs = 1'b1;
   logic        prev_ck = 1'b1;
   int          lo_len = 0, hi_len = 0, low_len = 0, nbits = 0;
   logic [15:0] shreg = '0;
   logic        frame_rs = 1'b1;

   task automatic frame_end();
      exp_t e;
      exp_t got;
      chk("hi_len_last", hi_len, CLK_DIV);
      chk("frame_len", low_len, nbits * 2 * CLK_DIV);
      got.pix = (nbits == 16);
      got.rs  = frame_rs;
      got.val = (nbits == 16) ? shreg : {8'h00, shreg[7:0]};
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_frame got=%h bits=%0d want=none", got, nbits);
      end else begin
         e = exp_q.pop_front();
         chk("frame", got, e);
      end
      if (nbits == 16) pix_seen++;
   endtask

   always @(negedge clk) begin
      if (!resetn) begin
         prev_cs = 1'b1;
         prev_ck = 1'b1;
         nbits   = 0;
      end else begin
         if (pix_ready)  pr_cnt++;
         if (frame_done) fd_cnt++;
`ifdef LCD_SPI_TESTPATTERN_EN
         chk("pix_ready_low", pix_ready, 0);
`endif
         if (lcd_cs) begin
            chk("idle_clk", lcd_clk, 1);
            if (!prev_cs) frame_end();
         end else begin
            if (prev_cs) begin
               lo_len = 0; hi_len = 0; low_len = 0; nbits = 0;
               shreg = '0; frame_rs = lcd_rs;
            end
            low_len++;
            if (!lcd_clk) begin
               if (prev_ck && !prev_cs) begin
                  chk("hi_len", hi_len, CLK_DIV);
                  hi_len = 0;
               end
               lo_len++;
            end else begin
               if (!prev_ck) begin
                  chk("lo_len", lo_len, CLK_DIV);
                  shreg = {shreg[14:0], lcd_data};
                  nbits++;
                  lo_len = 0;
               end
               hi_len++;
            end
         end
         prev_cs = lcd_cs;
         prev_ck = lcd_clk;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_lcd_resetn"}, lcd_resetn, 0);
      chk({tag, "_lcd_cs"}, lcd_cs, 1);
      chk({tag, "_lcd_rs"}, lcd_rs, 1);
      chk({tag, "_lcd_clk"}, lcd_clk, 1);
      chk({tag, "_lcd_data"}, lcd_data, 1);
      chk({tag, "_pix_ready"}, pix_ready, 0);
      chk({tag, "_init_done"}, init_done, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_frame_done"}, frame_done, 0);
   endtask

   task automatic power_up();
      int n;
      push_power();
      @(posedge clk); #1 resetn = 1'b1;
      n = 0;
      while (!lcd_resetn && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("lcd_resetn_delay", n, T_RESET);
      n = 0;
      while (!init_done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("init_done", init_done, 1);
      chk("init_bytes_left", exp_q.size(), 0);
      chk("busy_in_idle", busy, 0);
   endtask

   task automatic accept_pixel();
      int n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if (pix_ready) break;
         n++;
      end
      chk("pix_accept", pix_ready, 1);
      if (pix_ready) push_pix(pix_data);
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input bit underflow, input bit hold_fs, input bit fixed_first);
      int n;
      pr_cnt = 0; fd_cnt = 0; pix_seen = 0;
      push_window();
`ifdef LCD_SPI_TESTPATTERN_EN
      for (int p = 0; p < NPIX; p++) push_pix(pat(p));
`endif
      frame_start = 1'b1;
      @(posedge clk); #1 frame_start = hold_fs;
`ifndef LCD_SPI_TESTPATTERN_EN
      for (int p = 0; p < NPIX; p++) begin
         if (underflow && p == 2) begin
            pix_valid = 1'b0;
            n = 0;
            while (pix_seen < 2 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk); #1;
            repeat (10) begin @(posedge clk); #1; end
         end else if (!fixed_first && $urandom_range(0, 2) == 0) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
         end
         pix_data  = (fixed_first && p == 0) ? 16'hA55A : 16'($urandom);
         pix_valid = 1'b1;
         accept_pixel();
      end
      pix_valid = 1'b0;
`endif
      n = 0;
      while (!frame_done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("frame_done_seen", frame_done, 1);
      @(posedge clk); #1 frame_start = 1'b0;
      repeat (4) @(negedge clk);
`ifdef LCD_SPI_TESTPATTERN_EN
      chk("pix_ready_count", pr_cnt, 0);
`else
      chk("pix_ready_count", pr_cnt, NPIX);
`endif
      chk("frame_done_count", fd_cnt, 1);
      chk("busy_after_frame", busy, 0);
      chk("frame_queue_empty", exp_q.size(), 0);
   endtask

   task automatic abort_pixel();
      int n;
      pix_seen = 0;
      push_window();
      frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
`ifndef LCD_SPI_TESTPATTERN_EN
      for (int p = 0; p < 2; p++) begin
         pix_data  = 16'($urandom);
         pix_valid = 1'b1;
         accept_pixel();
      end
      pix_valid = 1'b0;
`endif
      n = 0;
      while (!(pix_seen >= 1 && !lcd_cs) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      chk("mid_pixel_cs", lcd_cs, 0);
      @(posedge clk); #1 resetn = 1'b0;
      #1;
      check_reset_outputs("abort");
      exp_q.delete();
      repeat (3) begin @(posedge clk); #1; end
      check_reset_outputs("abort_hold");
      power_up();
   endtask

   initial begin
      resetn = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
      repeat (3) begin @(posedge clk); #1; end
      check_reset_outputs("por");
      power_up();
      run_frame(1'b0, 1'b0, 1'b1);
      run_frame(1'b1, 1'b1, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0);
      abort_pixel();
      run_frame(1'b1, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
